// File: rtl/stream_crossbar.sv
// Packet-switched stream crossbar with one round-robin arbiter per output.
// Each arbiter holds its grant for a whole packet; the data path is combinational.
module stream_crossbar #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i
);

  localparam int DW = T_DATA_WIDTH;
  localparam int S  = S_DATA_COUNT;
  localparam int M  = M_DATA_COUNT;
  localparam int IW = T_ID___WIDTH;
  localparam int TW = T_DEST_WIDTH;

  logic [M-1:0]  lock;
  logic [IW-1:0] src [M];
  logic [IW-1:0] ptr [M];
  logic [M-1:0]  gv;
  logic [IW-1:0] g [M];

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin : arb
    int idx;
    idx = 0;
    for (int m = 0; m < M; m++) begin
      gv[m] = 1'b0;
      g[m]  = '0;
      if (lock[m]) begin
        gv[m] = 1'b1;
        g[m]  = src[m];
      end else begin
        for (int k = S - 1; k >= 0; k--) begin
          idx = (int'(ptr[m]) + k) % S;
          if (s_valid_i[idx] &&
              s_dest_i[idx*TW +: TW] == TW'(m)) begin
            gv[m] = 1'b1;
            g[m]  = IW'(idx);
          end
        end
      end
    end
  end

  always_comb begin : fwd
    int  gi;
    logic hit;
    gi        = 0;
    hit       = 1'b0;
    m_valid_o = '0;
    m_data_o  = '0;
    m_id_o    = '0;
    m_last_o  = '0;
    s_ready_o = '0;
    for (int m = 0; m < M; m++) begin
      if (gv[m]) begin
        gi  = int'(g[m]);
        hit = (s_dest_i[gi*TW +: TW] == TW'(m));
        m_valid_o[m]         = s_valid_i[gi] && hit;
        m_data_o[m*DW +: DW] = s_data_i[gi*DW +: DW];
        m_id_o[m*IW +: IW]   = g[m];
        m_last_o[m]          = s_last_i[gi];
        if (hit && m_ready_i[m])
          s_ready_o[gi] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= '0;
      for (int m = 0; m < M; m++) begin
        src[m] <= '0;
        ptr[m] <= '0;
      end
    end else begin
      for (int m = 0; m < M; m++) begin
        if (m_valid_o[m] && m_ready_i[m]) begin
          if (m_last_o[m]) begin
            lock[m] <= 1'b0;
            ptr[m]  <= IW'((int'(g[m]) + 1) % S);
          end else begin
            lock[m] <= 1'b1;
            src[m]  <= g[m];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_crossbar.sv
// Scoreboard bench for stream_crossbar: directed packets, queued expectations,
// and a negedge monitor that pops one entry per output transfer.
module tb_stream_crossbar;

  localparam int DW = 8;
  localparam int S  = 5;
  localparam int M  = 3;
  localparam int IW = 3;
  localparam int TW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW*S-1:0] s_data;
  logic [TW*S-1:0] s_dest;
  logic [S-1:0]    s_last, s_valid, s_ready;
  logic [DW*M-1:0] m_data;
  logic [IW*M-1:0] m_id;
  logic [M-1:0]    m_last, m_valid, m_ready;

  logic [DW-1:0] d  [S];
  logic [TW-1:0] ds [S];

  always_comb begin
    s_data = '0;
    s_dest = '0;
    for (int i = 0; i < S; i++) begin
      s_data[i*DW +: DW] = d[i];
      s_dest[i*TW +: TW] = ds[i];
    end
  end

  stream_crossbar dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_dest_i  (s_dest),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_id_o    (m_id),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  int total = 0;
  int bad   = 0;
  exp_t q [M][$];
  exp_t me;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int m, input int id, input int dt,
                      input bit l);
    exp_t e;
    e.id   = id[IW-1:0];
    e.data = dt[DW-1:0];
    e.last = l;
    q[m].push_back(e);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    for (int i = 0; i < S; i++) begin
      d[i]  = '0;
      ds[i] = '0;
    end
    s_last  = '0;
    s_valid = '0;
    m_ready = '1;
  endtask

  task automatic do_reset;
    idle;
    rst_n = 1'b0;
    nxt;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < M; m++) begin
        if (m_valid[m] && m_ready[m]) begin
          if (q[m].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat out=%0d id=%0d data=%h",
                     m, m_id[m*IW +: IW], m_data[m*DW +: DW]);
          end else begin
            me = q[m].pop_front();
            chk($sformatf("mon_id%0d", m), 32'(m_id[m*IW +: IW]),
                32'(me.id));
            chk($sformatf("mon_data%0d", m), 32'(m_data[m*DW +: DW]),
                32'(me.data));
            chk($sformatf("mon_last%0d", m), 32'(m_last[m]),
                32'(me.last));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_data", 32'(m_data), 32'h0);
    chk("rst_id", 32'(m_id), 32'h0);
    chk("rst_last", 32'(m_last), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    nxt;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(m_valid), 32'h0);
    chk("post_rst_ready", 32'(s_ready), 32'h0);
    nxt;

    // parallel routing; input 1 targets a nonexistent output
    d[0] = 8'hF0; ds[0] = 2'd0;
    d[1] = 8'h11; ds[1] = 2'd3;
    d[2] = 8'hAA; ds[2] = 2'd1;
    d[4] = 8'hFF; ds[4] = 2'd2;
    s_last  = '1;
    s_valid = 5'b10111;
    push(0, 0, 'hF0, 1);
    push(1, 2, 'hAA, 1);
    push(2, 4, 'hFF, 1);
    @(negedge clk);
    chk("par_data", 32'(m_data), 32'hFFAAF0);
    chk("par_id", 32'(m_id), 32'(9'b100_010_000));
    chk("par_valid", 32'(m_valid), 32'h7);
    chk("par_last", 32'(m_last), 32'h7);
    chk("par_ready", 32'(s_ready), 32'(5'b10101));
    nxt;

    // five-way contention on output 0
    do_reset;
    for (int i = 0; i < S; i++) begin
      d[i]  = 8'(8'h10 + i);
      ds[i] = 2'd0;
    end
    s_valid = '1;
    s_last  = '1;
    for (int k = 0; k < S; k++) push(0, k, 'h10 + k, 1);
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ready%0d", k), 32'(s_ready), 32'(1 << k));
      chk($sformatf("rr_id%0d", k), 32'(m_id[2:0]), 32'(k));
      nxt;
    end
    idle;

    // packet lock with a mid-packet gap
    do_reset;
    ds[1] = 2'd1; ds[2] = 2'd1;
    d[2] = 8'h42; s_last[2] = 1'b1; s_valid[2] = 1'b1;
    d[1] = 8'h31; s_last[1] = 1'b0; s_valid[1] = 1'b1;
    push(1, 1, 'h31, 0);
    @(negedge clk);
    chk("lock_b0_ready", 32'(s_ready), 32'(5'b00010));
    nxt;
    s_valid[1] = 1'b0;
    @(negedge clk);
    chk("lock_gap_valid", 32'(m_valid[1]), 32'h0);
    chk("lock_gap_ready2", 32'(s_ready[2]), 32'h0);
    nxt;
    s_valid[1] = 1'b1; d[1] = 8'h32;
    push(1, 1, 'h32, 0);
    @(negedge clk);
    chk("lock_b1_ready2", 32'(s_ready[2]), 32'h0);
    chk("lock_b1_id", 32'(m_id[5:3]), 32'h1);
    nxt;
    d[1] = 8'h33; s_last[1] = 1'b1;
    push(1, 1, 'h33, 1);
    @(negedge clk);
    chk("lock_b2_ready2", 32'(s_ready[2]), 32'h0);
    nxt;
    s_valid[1] = 1'b0;
    push(1, 2, 'h42, 1);
    @(negedge clk);
    chk("lock_next_ready", 32'(s_ready), 32'(5'b00100));
    nxt;
    idle;

    // backpressure on output 2
    do_reset;
    ds[3] = 2'd2; d[3] = 8'h5A; s_last[3] = 1'b1; s_valid[3] = 1'b1;
    m_ready = 3'b011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(m_valid[2]), 32'h1);
      chk("bp_ready", 32'(s_ready[3]), 32'h0);
      chk("bp_data", 32'(m_data[23:16]), 32'h5A);
      nxt;
    end
    m_ready = '1;
    push(2, 3, 'h5A, 1);
    @(negedge clk);
    chk("bp_release", 32'(s_ready[3]), 32'h1);
    nxt;
    idle;

    // mixed contention
    do_reset;
    for (int i = 0; i < S; i++) d[i] = 8'(8'hA0 + i);
    ds[0] = 2'd0; ds[1] = 2'd1; ds[2] = 2'd1; ds[3] = 2'd2; ds[4] = 2'd2;
    s_valid = '1;
    s_last  = '0;
    push(0, 0, 'hA0, 0); push(1, 1, 'hA1, 0); push(2, 3, 'hA3, 0);
    @(negedge clk);
    chk("mix_id0", 32'(m_id), 32'(9'b011_001_000));
    chk("mix_ready0", 32'(s_ready), 32'(5'b01011));
    nxt;
    s_last = 5'b01011;
    push(0, 0, 'hA0, 1); push(1, 1, 'hA1, 1); push(2, 3, 'hA3, 1);
    @(negedge clk);
    chk("mix_id1", 32'(m_id), 32'(9'b011_001_000));
    chk("mix_last1", 32'(m_last), 32'h7);
    nxt;
    s_valid = 5'b10100;
    s_last  = 5'b10100;
    push(1, 2, 'hA2, 1); push(2, 4, 'hA4, 1);
    @(negedge clk);
    chk("mix_id2", 32'(m_id), 32'(9'b100_010_000));
    chk("mix_valid2", 32'(m_valid), 32'(3'b110));
    nxt;
    idle;

    // reset while output 0 is locked to source 3
    do_reset;
    ds[3] = 2'd0; d[3] = 8'h77; s_last[3] = 1'b0; s_valid[3] = 1'b1;
    push(0, 3, 'h77, 0);
    @(negedge clk);
    chk("rm_first", 32'(m_id[2:0]), 32'h3);
    nxt;
    ds[0] = 2'd0; d[0] = 8'h66; s_last[0] = 1'b1; s_valid[0] = 1'b1;
    m_ready[0] = 1'b0;
    @(negedge clk);
    chk("rm_locked_id", 32'(m_id[2:0]), 32'h3);
    chk("rm_locked_ready", 32'(s_ready), 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_rst_id", 32'(m_id[2:0]), 32'h0);
    chk("rm_rst_data", 32'(m_data[7:0]), 32'h66);
    nxt;
    rst_n = 1'b1;
    m_ready = '1;
    push(0, 0, 'h66, 1);
    @(negedge clk);
    chk("rm_after_ready", 32'(s_ready), 32'(5'b00001));
    nxt;
    idle;
    nxt;

    for (int m = 0; m < M; m++)
      chk($sformatf("drain%0d", m), 32'(q[m].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_crossbar.md
Name: stream_crossbar

Overview:
- Packet-switched streaming crossbar with valid/ready/last handshake on every port.
- Connects S_DATA_COUNT slave (input) streams to M_DATA_COUNT master (output) streams.
- Each input steers its packets with a destination index.
- Each output runs an independent round-robin arbiter that locks onto one source for a whole packet and tags output beats with the source index. Data path is combinational (zero latency).

Parameters:
- T_DATA_WIDTH, 8, data bits per stream.
- S_DATA_COUNT, 5, number of input streams.
- M_DATA_COUNT, 3, number of output streams.
- T_ID___WIDTH, $clog2(S_DATA_COUNT), width of source id.
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), width of destination field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data_i  input  T_DATA_WIDTH*S_DATA_COUNT  input data; slice i = bits [i*T_DATA_WIDTH +: T_DATA_WIDTH].
- s_dest_i  input  T_DEST_WIDTH*S_DATA_COUNT  destination output index per input.
- s_last_i  input  S_DATA_COUNT  last beat of packet per input.
- s_valid_i  input  S_DATA_COUNT  beat valid per input.
- s_ready_o  output  S_DATA_COUNT  beat accepted per input.
- m_data_o  output  T_DATA_WIDTH*M_DATA_COUNT  output data; slice m = granted source's data.
- m_id_o  output  T_ID___WIDTH*M_DATA_COUNT  index of the source driving output m.
- m_last_o  output  M_DATA_COUNT  last flag forwarded from the granted source.
- m_valid_o  output  M_DATA_COUNT  output valid.
- m_ready_i  input  M_DATA_COUNT  downstream ready.

Behaviour:
- Request: input i requests output m when s_valid_i[i]=1 and s_dest_i[i]==m. A dest >= M_DATA_COUNT requests nothing; that input's s_ready_o stays 0.
- Per-output state: lock flag, granted-source register, round-robin pointer ptr (next highest priority).
- Idle output (lock=0), combinational grant: first requesting source scanning ptr, ptr+1, ..., wrapping modulo S_DATA_COUNT. No requester means no grant.
- Locked output: grant = stored source, regardless of other requests. Its s_dest_i must stay stable during the packet.
- Forwarding, combinational:
  - m_valid_o[m] = s_valid_i[g] && s_dest_i[g]==m, where g is the granted source.
  - m_data_o, m_last_o = source g's data and last; m_id_o = g.
  - With no grant, m_valid=0 and m_data/m_id/m_last are all 0.
- s_ready_o[i] = 1 iff some output m grants i, i's request targets m, and m_ready_i[m]=1. No combinational path from s_valid_i[i] to s_ready_o[i] beyond the grant.
- Transfer on output m = m_valid_o[m] && m_ready_i[m] at a rising clk.
  - Transfer with last=0: lock=1, stored source = g.
  - Transfer with last=1: lock=0, ptr = (g+1) mod S_DATA_COUNT. A single-beat packet never locks.
- A valid-low gap mid-packet keeps the lock; other sources stay blocked.
- Outputs are fully independent. Different outputs can serve different sources in the same cycle; one input is served by at most one output.
- Reset (rst_n=0, asynchronous): all locks clear, all ptr = 0.
  - With no s_valid_i, all outputs are 0 during and after reset.
  - Reset mid-packet drops the lock; the next grant is by priority from source 0.
- Simultaneous events: re-arbitration happens in the cycle after a last transfer. A new packet on the same output may be granted in that next cycle with no bubble.

Test Plan:
- Parallel routing after reset:
  - Stimulus: dest 0->0, 2->1, 4->2; those inputs valid with last=1; data F0, AA, FF; m_ready=111.
  - Response: m_data=FF_AA_F0, m_id=100_010_000, m_valid=111, m_last=111, s_ready=10101.
- Five-way contention on output 0:
  - Stimulus: all inputs valid, dest 0, each sends a 1-beat packet; ready=1.
  - Response: m_id[0] goes 0,1,2,3,4 on consecutive cycles. s_ready is one-hot on the granted source; other inputs stall.
- Packet lock:
  - Stimulus: input 1 (dest 1) sends 3 beats, last on beat 3; input 2 (dest 1) is valid throughout.
  - Response: m_id[1]=1 for 3 transfers, then 2. s_ready[2]=0 until input 1's last transfer completes.
- Backpressure:
  - Stimulus: granted packet on output 2 with m_ready[2]=0.
  - Response: m_valid[2]=1, s_ready of that source is 0, data held; the transfer completes the cycle ready rises.
- Mixed contention:
  - Stimulus: dest 0->0, 1,2->1, 3,4->2, all valid, last=0, then last on inputs 0,1,3.
  - Response: first m_id=011_001_000; after the last transfers, m_id=100_010_000.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 while output 0 is locked to source 3, then release with sources 0 and 3 requesting.
  - Response: output 0 is granted to source 0.
